// File: rtl/frame_clear_engine.sv
// frame_clear_engine: sweeps every framebuffer pixel in raster order writing a constant clear colour
module frame_clear_engine #(
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 480,
  parameter int COLOR_W = 8,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               clear_start,
  input  logic               mem_ready,
  output logic [9:0]         clear_DrawX,
  output logic [9:0]         clear_DrawY,
  output logic               clear_we,
  output logic [COLOR_W-1:0] clear_color,
  output logic               clear_done
);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  localparam logic [9:0] X_LAST = 10'(H_PIXELS - 1);
  localparam logic [9:0] Y_LAST = 10'(V_PIXELS - 1);
  state_t state, state_n;
  logic [9:0] x_n, y_n;
  logic we_n, done_n, last_x, last_y;
  assign clear_color = CLEAR_COLOR;
  assign last_x = clear_DrawX == X_LAST;
  assign last_y = clear_DrawY == Y_LAST;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      clear_DrawX <= '0;
      clear_DrawY <= '0;
      clear_we <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state <= state_n;
      clear_DrawX <= x_n;
      clear_DrawY <= y_n;
      clear_we <= we_n;
      clear_done <= done_n;
    end
  always_comb begin
    state_n = state;
    x_n = clear_DrawX;
    y_n = clear_DrawY;
    we_n = clear_we;
    done_n = clear_done;
    case (state)
      IDLE: begin
        x_n = '0;
        y_n = '0;
        we_n = clear_start;
        done_n = 1'b0;
        state_n = clear_start ? SWEEP : IDLE;
      end
      SWEEP:
        if (!clear_start) begin
          state_n = IDLE;
          x_n = '0;
          y_n = '0;
          we_n = 1'b0;
          done_n = 1'b0;
        end else if (mem_ready && last_x && last_y) begin
          // coordinates rest on the final pixel until the handshake closes
          state_n = DONE;
          we_n = 1'b0;
          done_n = 1'b1;
        end else if (mem_ready) begin
          x_n = last_x ? '0 : clear_DrawX + 10'd1;
          y_n = last_x ? clear_DrawY + 10'd1 : clear_DrawY;
        end
      DONE:
        if (!clear_start) begin
          state_n = IDLE;
          x_n = '0;
          y_n = '0;
          done_n = 1'b0;
        end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_frame_clear_engine.sv
// tb_frame_clear_engine: vector table, directed corner sequences and random traffic against a pixel-index model
module tb_frame_clear_engine;
  localparam int H = 4;
  localparam int V = 3;
  localparam int N = H * V;
  localparam logic [7:0] COLOR = 8'hA5;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic clear_start = 1'b0;
  logic mem_ready = 1'b0;
  logic [9:0] clear_DrawX, clear_DrawY;
  logic clear_we, clear_done;
  logic [7:0] clear_color;
  int checks = 0;
  int errors = 0;
  int mode = 0;
  int p = 0;
  int seen[N];
  frame_clear_engine #(.H_PIXELS(H), .V_PIXELS(V), .COLOR_W(8), .CLEAR_COLOR(COLOR)) dut (
    .Clk(Clk), .Reset(Reset), .clear_start(clear_start), .mem_ready(mem_ready),
    .clear_DrawX(clear_DrawX), .clear_DrawY(clear_DrawY), .clear_we(clear_we),
    .clear_color(clear_color), .clear_done(clear_done)
  );
  always #5 Clk = ~Clk;
  typedef struct {
    logic s, r, we, done;
    int x, y;
  } vec_t;
  vec_t vt[15];
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", n, act, exp);
    end
  endtask
  task automatic clear_seen();
    for (int i = 0; i < N; i++) seen[i] = 0;
  endtask
  task automatic cyc(input logic s, input logic r);
    logic pw;
    int px, py;
    clear_start = s;
    mem_ready = r;
    pw = clear_we;
    px = int'(clear_DrawX);
    py = int'(clear_DrawY);
    if (pw && r) chk("color", int'(clear_color), int'(COLOR));
    @(posedge Clk);
    #1;
    if (pw && r) begin
      if (px < H && py < V) seen[py * H + px]++;
      else chk("coord_range", py * H + px, N - 1);
    end
    if (mode == 0) begin
      if (s) begin
        mode = 1;
        p = 0;
        clear_seen();
      end
    end else if (mode == 1) begin
      if (!s) begin
        mode = 0;
        p = 0;
        clear_seen();
      end else if (r) begin
        if (p == N - 1) begin
          mode = 2;
          for (int i = 0; i < N; i++) chk($sformatf("written_once[%0d]", i), seen[i], 1);
          clear_seen();
        end else p++;
      end
    end else if (!s) begin
      mode = 0;
      p = 0;
    end
    chk("we", int'(clear_we), int'(mode == 1));
    chk("done", int'(clear_done), int'(mode == 2));
    if (mode != 2) begin
      chk("x", int'(clear_DrawX), p % H);
      chk("y", int'(clear_DrawY), p / H);
    end
  endtask
  task automatic async_reset();
    Reset = 1'b1;
    #1;
    chk("rst_we", int'(clear_we), 0);
    chk("rst_done", int'(clear_done), 0);
    chk("rst_x", int'(clear_DrawX), 0);
    chk("rst_y", int'(clear_DrawY), 0);
    Reset = 1'b0;
    mode = 0;
    p = 0;
    clear_seen();
  endtask
  initial begin
    logic [9:0] hx, hy;
    clear_seen();
    vt[0] = '{s: 1, r: 1, we: 1, done: 0, x: 0, y: 0};
    for (int k = 1; k < 12; k++) vt[k] = '{s: 1, r: 1, we: 1, done: 0, x: k % 4, y: k / 4};
    vt[12] = '{s: 1, r: 1, we: 0, done: 1, x: -1, y: -1};
    vt[13] = '{s: 1, r: 0, we: 0, done: 1, x: -1, y: -1};
    vt[14] = '{s: 0, r: 1, we: 0, done: 0, x: 0, y: 0};
    #2;
    chk("reset_we", int'(clear_we), 0);
    chk("reset_done", int'(clear_done), 0);
    chk("reset_x", int'(clear_DrawX), 0);
    chk("reset_y", int'(clear_DrawY), 0);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc(vt[i].s, vt[i].r);
      chk($sformatf("vec%0d_we", i), int'(clear_we), int'(vt[i].we));
      chk($sformatf("vec%0d_done", i), int'(clear_done), int'(vt[i].done));
      if (vt[i].x >= 0) begin
        chk($sformatf("vec%0d_x", i), int'(clear_DrawX), vt[i].x);
        chk($sformatf("vec%0d_y", i), int'(clear_DrawY), vt[i].y);
      end
    end
    cyc(1, 1);
    repeat (6) cyc(1, 1);
    repeat (3) begin
      cyc(1, 0);
      chk("stall_x", int'(clear_DrawX), 2);
      chk("stall_y", int'(clear_DrawY), 1);
      chk("stall_we", int'(clear_we), 1);
    end
    repeat (5) cyc(1, 1);
    chk("stall_not_done_14", int'(clear_done), 0);
    cyc(1, 1);
    chk("stall_done_15", int'(clear_done), 1);
    hx = clear_DrawX;
    hy = clear_DrawY;
    repeat (50) begin
      cyc(1, $urandom_range(0, 1) == 1);
      chk("hold_x", int'(clear_DrawX), int'(hx));
      chk("hold_y", int'(clear_DrawY), int'(hy));
    end
    cyc(0, 1);
    chk("release_done", int'(clear_done), 0);
    cyc(1, 1);
    repeat (9) cyc(1, 1);
    chk("abort_at_x", int'(clear_DrawX), 1);
    chk("abort_at_y", int'(clear_DrawY), 2);
    cyc(0, 1);
    chk("abort_we", int'(clear_we), 0);
    chk("abort_x", int'(clear_DrawX), 0);
    chk("abort_y", int'(clear_DrawY), 0);
    repeat (3) cyc(0, 1);
    chk("abort_no_done", int'(clear_done), 0);
    cyc(1, 1);
    chk("restart_x", int'(clear_DrawX), 0);
    chk("restart_y", int'(clear_DrawY), 0);
    chk("restart_we", int'(clear_we), 1);
    repeat (7) cyc(1, 1);
    chk("pre_rst_x", int'(clear_DrawX), 3);
    chk("pre_rst_y", int'(clear_DrawY), 1);
    async_reset();
    cyc(1, 1);
    chk("post_rst_x", int'(clear_DrawX), 0);
    chk("post_rst_we", int'(clear_we), 1);
    repeat (11) cyc(1, 1);
    cyc(0, 1);
    chk("final_abort_done", int'(clear_done), 0);
    cyc(0, 0);
    for (int i = 0; i < 3000; i++) cyc($urandom_range(0, 31) != 0, $urandom_range(0, 9) < 7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
